// File: rtl/fb_pkg.sv
// Shared constants and state encoding for the 320x240 RGB444 page frame buffer.
package fb_pkg;

   localparam int unsigned FB_H_RES  = 320;
   localparam int unsigned FB_V_RES  = 240;
   localparam int unsigned FB_PIX_W  = 12;
   localparam int unsigned FB_ADDR_W = 19;
   localparam int unsigned FB_PIXELS = FB_H_RES * FB_V_RES;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOF = 2'd1,
`ifdef FB_PAGE_WRITER_CLEAR_EN
      WRITE    = 2'd2,
      CLEAR    = 2'd3
`else
      WRITE    = 2'd2
`endif
   } fb_wr_state_t;

endpackage

// File: rtl/fb_raster_counter.sv
// Raster x/y position plus linear address, kept as counters (no multiplier).
// clr and inc together load the position after (0,0).
module fb_raster_counter
   import fb_pkg::*;
#(
   parameter int unsigned H_RES = FB_H_RES,
   parameter int unsigned V_RES = FB_V_RES,
   localparam int unsigned XW = $clog2(H_RES),
   localparam int unsigned YW = $clog2(V_RES),
   localparam int unsigned AW = $clog2(H_RES * V_RES)
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   input  logic          clr,
   input  logic          inc,
   output logic [AW-1:0] addr,
   output logic          last
);

   localparam logic [XW-1:0] XMax = XW'(H_RES - 1);
   localparam logic [AW-1:0] AMax = AW'(H_RES * V_RES - 1);

   logic [XW-1:0] x_q, x_d, x_base;
   logic [YW-1:0] y_q, y_d, y_base;
   logic [AW-1:0] a_q, a_d, a_base;

   always_comb begin
      x_base = clr ? '0 : x_q;
      y_base = clr ? '0 : y_q;
      a_base = clr ? '0 : a_q;
      x_d    = x_base;
      y_d    = y_base;
      a_d    = a_base;
      if (inc) begin
         // Wrap to origin after the last pixel so an idle block rests at (0,0).
         if (a_base == AMax) begin
            x_d = '0;
            y_d = '0;
            a_d = '0;
         end else if (x_base == XMax) begin
            x_d = '0;
            y_d = y_base + YW'(1);
            a_d = a_base + AW'(1);
         end else begin
            x_d = x_base + XW'(1);
            a_d = a_base + AW'(1);
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         x_q <= '0;
         y_q <= '0;
         a_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
         a_q <= a_d;
      end
   end

   assign addr = a_base;
   assign last = (a_q == AMax);

endmodule

// File: rtl/fb_page_writer.sv
// Write side of the page frame buffer: raster stream -> linear writes.
// Define FB_PAGE_WRITER_CLEAR_EN to build the single-colour page clear engine.
module fb_page_writer
   import fb_pkg::*;
#(
   parameter int unsigned H_RES  = FB_H_RES,
   parameter int unsigned V_RES  = FB_V_RES,
   parameter int unsigned DATA_W = FB_PIX_W,
   parameter int unsigned ADDR_W = FB_ADDR_W
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              start,
`ifdef FB_PAGE_WRITER_CLEAR_EN
   input  logic              clear,
   input  logic [DATA_W-1:0] clear_color,
`endif
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              s_sof,
   input  logic [DATA_W-1:0] s_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic              frame_err
);

   localparam int unsigned AW = $clog2(H_RES * V_RES);

   fb_wr_state_t      state_q, state_d;
   logic              beat;
   logic              cnt_clr, cnt_inc, cnt_last;
   logic [AW-1:0]     cnt_addr;
   logic              wr_fire, fin, err;
   logic [DATA_W-1:0] fire_data;
`ifdef FB_PAGE_WRITER_CLEAR_EN
   logic [DATA_W-1:0] color_q;
`endif

   assign s_ready = (state_q == WAIT_SOF) || (state_q == WRITE);
   assign busy    = (state_q != IDLE);
   assign beat    = s_valid && s_ready;

   fb_raster_counter #(
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) u_raster (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .clr     (cnt_clr),
      .inc     (cnt_inc),
      .addr    (cnt_addr),
      .last    (cnt_last)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
`ifdef FB_PAGE_WRITER_CLEAR_EN
            if (clear) begin
               state_d = CLEAR;
            end else if (start) begin
               state_d = WAIT_SOF;
            end
`else
            if (start) begin
               state_d = WAIT_SOF;
            end
`endif
         end
         WAIT_SOF: begin
            if (beat && s_sof) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (beat && cnt_last && !s_sof) begin
               state_d = IDLE;
            end
         end
`ifdef FB_PAGE_WRITER_CLEAR_EN
         CLEAR: begin
            if (cnt_last) begin
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      wr_fire   = 1'b0;
      fin       = 1'b0;
      err       = 1'b0;
      fire_data = s_data;
      case (state_q)
         IDLE: begin
            cnt_clr = 1'b1;
`ifdef FB_PAGE_WRITER_CLEAR_EN
            // Address 0 of a fill is issued from IDLE so it lands the cycle after clear.
            if (clear) begin
               cnt_inc   = 1'b1;
               wr_fire   = 1'b1;
               fire_data = clear_color;
            end
`endif
         end
         WAIT_SOF: begin
            if (beat && s_sof) begin
               cnt_clr = 1'b1;
               cnt_inc = 1'b1;
               wr_fire = 1'b1;
            end
         end
         WRITE: begin
            if (beat) begin
               cnt_clr = s_sof;
               cnt_inc = 1'b1;
               wr_fire = 1'b1;
               err     = s_sof;
               fin     = cnt_last && !s_sof;
            end
         end
`ifdef FB_PAGE_WRITER_CLEAR_EN
         CLEAR: begin
            cnt_inc   = 1'b1;
            wr_fire   = 1'b1;
            fire_data = color_q;
            fin       = cnt_last;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         done      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         wr_en     <= wr_fire;
         done      <= fin;
         frame_err <= err;
         if (wr_fire) begin
            wr_addr <= ADDR_W'(cnt_addr);
            wr_data <= fire_data;
         end
      end
   end

`ifdef FB_PAGE_WRITER_CLEAR_EN
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         color_q <= '0;
      end else if (state_q == IDLE && clear) begin
         color_q <= clear_color;
      end
   end
`endif

endmodule

// File: tb/tb_fb_page_writer.sv
// Directed bench for fb_page_writer on a reduced 10x6 raster.
module tb_fb_page_writer;

   localparam int H = 10;
   localparam int V = 6;
   localparam int PIX = H * V;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        start = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_sof = 1'b0;
   logic [11:0] s_data = '0;
   logic        s_ready;
   logic        wr_en;
   logic [18:0] wr_addr;
   logic [11:0] wr_data;
   logic        busy, done, frame_err;
`ifdef FB_PAGE_WRITER_CLEAR_EN
   logic        clear = 1'b0;
   logic [11:0] clear_color = '0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 sys_clk = ~sys_clk;

   fb_page_writer #(
      .H_RES  (H),
      .V_RES  (V),
      .DATA_W (12),
      .ADDR_W (19)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .start       (start),
`ifdef FB_PAGE_WRITER_CLEAR_EN
      .clear       (clear),
      .clear_color (clear_color),
`endif
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_sof       (s_sof),
      .s_data      (s_data),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy),
      .done        (done),
      .frame_err   (frame_err)
   );

   typedef struct {
      logic        rst, strt, valid, sof;
      logic [11:0] data;
      logic        e_ready, e_busy, e_en, chk_ad;
      logic [18:0] e_addr;
      logic [11:0] e_data;
      logic        e_done, e_err;
   } vec_t;

   vec_t vecs[12];

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Drive one cycle of stream input, then check the registered write port.
   task automatic step(input logic v, input logic sof, input logic [11:0] d, input logic e_en,
                       input int e_addr, input logic e_done, input logic e_err,
                       input string tag);
      s_valid = v;
      s_sof   = sof;
      s_data  = d;
      tick();
      s_valid = 1'b0;
      s_sof   = 1'b0;
      check({tag, " en/done/err"}, {61'd0, wr_en, done, frame_err}, {61'd0, e_en, e_done, e_err});
      if (e_en) begin
         check({tag, " addr"}, {45'd0, wr_addr}, {45'd0, 19'(e_addr)});
         check({tag, " data"}, {52'd0, wr_data}, {52'd0, d});
      end
   endtask

   task automatic do_start(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, " ready/busy"}, {62'd0, s_ready, busy}, 64'd3);
   endtask

   // Bench model: positions tracked as (x,y); address computed as y*H+x.
   task automatic run_frame(input int sof_at, input int gap_pct, input string tag);
      int x, y, n, budget, a;
      logic v, restart, fin;
      logic [11:0] d;
      x = 0; y = 0; n = 0; fin = 1'b0;
      budget = 20 * PIX;
      while (!fin && budget > 0) begin
         budget--;
         v = ($urandom_range(99) >= gap_pct);
         if (!v) begin
            step(1'b0, 1'b0, 12'h000, 1'b0, 0, 1'b0, 1'b0, {tag, " gap"});
         end else begin
            restart = (n == 0) || (n == sof_at);
            if (restart) begin
               x = 0;
               y = 0;
            end
            a = y * H + x;
            d = 12'(a * 7 + 3 + n);
            fin = (a == PIX - 1);
            step(1'b1, restart, d, 1'b1, a, fin, (n == sof_at), tag);
            n++;
            x++;
            if (x == H) begin
               x = 0;
               y++;
            end
         end
      end
      check({tag, " completed"}, {63'd0, fin}, 64'd1);
      check({tag, " idle after done"}, {62'd0, s_ready, busy}, 64'd0);
   endtask

   initial begin
      // rst start valid sof data | ready busy en chk_ad addr data done err
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 19'd0, 12'h000, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h777, 1'b0, 1'b0, 1'b0, 1'b1, 19'd0, 12'h000, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 19'd0, 12'h000, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 12'hAAA, 1'b1, 1'b1, 1'b0, 1'b0, 19'd0, 12'h000, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h555, 1'b1, 1'b1, 1'b0, 1'b0, 19'd0, 12'h000, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 19'd0, 12'h000, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h123, 1'b1, 1'b1, 1'b1, 1'b1, 19'd0, 12'h123, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 19'd0, 12'h000, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h321, 1'b1, 1'b1, 1'b1, 1'b1, 19'd1, 12'h321, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h0F0, 1'b1, 1'b1, 1'b1, 1'b1, 19'd2, 12'h0F0, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b1, 19'd0, 12'h000, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h456, 1'b0, 1'b0, 1'b0, 1'b0, 19'd0, 12'h000, 1'b0, 1'b0};

      for (int i = 0; i < 12; i++) begin
         sys_rst = vecs[i].rst;
         start   = vecs[i].strt;
         s_valid = vecs[i].valid;
         s_sof   = vecs[i].sof;
         s_data  = vecs[i].data;
         tick();
         check($sformatf("vec%0d ctl", i),
               {59'd0, s_ready, busy, wr_en, done, frame_err},
               {59'd0, vecs[i].e_ready, vecs[i].e_busy, vecs[i].e_en, vecs[i].e_done,
                vecs[i].e_err});
         if (vecs[i].chk_ad) begin
            check($sformatf("vec%0d addr/data", i), {33'd0, wr_addr, wr_data},
                  {33'd0, vecs[i].e_addr, vecs[i].e_data});
         end
      end
      sys_rst = 1'b0;
      start   = 1'b0;
      s_valid = 1'b0;
      s_sof   = 1'b0;
      tick();

      // Full frame with ~30% stream gaps, then an immediate restart with a mid-frame SOF.
      do_start("frame_gaps start");
      run_frame(-1, 30, "frame_gaps");
      do_start("sof_mid start");
      run_frame(25, 0, "sof_mid");

      // Reset in the middle of a frame.
      do_start("rst_mid start");
      for (int i = 0; i < 30; i++) begin
         step(1'b1, (i == 0), 12'(i + 1), 1'b1, i, 1'b0, 1'b0, "rst_mid beat");
      end
      sys_rst = 1'b1;
      s_valid = 1'b1;
      tick();
      check("rst_mid outputs",
            {30'd0, s_ready, busy, wr_en, wr_addr, wr_data, done, frame_err}, 64'd0);
      sys_rst = 1'b0;
      s_valid = 1'b0;
      tick();
      do_start("post_rst start");
      run_frame(-1, 10, "post_rst");

`ifdef FB_PAGE_WRITER_CLEAR_EN
      // Clear beats a simultaneous start; colour is captured on the clear cycle only.
      tick();
      clear       = 1'b1;
      start       = 1'b1;
      clear_color = 12'hF00;
      tick();
      clear       = 1'b0;
      start       = 1'b0;
      clear_color = 12'h0AB;
      for (int i = 0; i < PIX; i++) begin
         if (i > 0) tick();
         check($sformatf("clear w%0d", i),
               {30'd0, s_ready, wr_en, wr_addr, wr_data, done},
               {30'd0, 1'b0, 1'b1, 19'(i), 12'hF00, (i == PIX - 1)});
      end
      check("clear idle after done", {63'd0, busy}, 64'd0);
      tick();
      check("clear start ignored", {61'd0, busy, wr_en, done}, 64'd0);
      do_start("after_clear start");
      run_frame(-1, 0, "after_clear");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fb_page_writer.md
# fb_page_writer

Upstream write-side stage of the 320×240 12-bit page frame buffer. Accepts a raster-ordered pixel stream with a valid/ready handshake and start-of-frame marker, generates linear frame-buffer addresses, and drives the buffer's write port. The VGA scan-out stage reads the same buffer and upscales it 2×. Optional clear engine fills the whole page with one colour between pages.

## Interface
- `H_RES`, 320: pixels per line.
- `V_RES`, 240: lines per frame.
- `DATA_W`, 12: pixel width, RGB444.
- `ADDR_W`, 19: write-address width, matching the buffer port.

Ports:
- `sys_clk` in 1: single clock. All logic runs in this domain.
- `sys_rst` in 1: reset, **synchronous and active-high**.
- `start` in 1: one-cycle pulse that arms the block to receive one frame.
- `clear` in 1: one-cycle pulse that starts the fill. Present only with `FB_PAGE_WRITER_CLEAR_EN`.
- `clear_color` in DATA_W: fill colour. Present only with the macro.
- `s_valid` in 1: stream beat valid.
- `s_ready` out 1: stream beat ready.
- `s_sof` in 1: the beat is pixel (0,0).
- `s_data` in DATA_W: pixel value.
- `wr_en` out 1: buffer write strobe.
- `wr_addr` out ADDR_W: buffer address, equal to y*H_RES+x and zero-extended.
- `wr_data` out DATA_W: buffer data.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse that coincides with the final write of a frame or fill.
- `frame_err` out 1: one-cycle pulse when `s_sof` arrives mid-frame.

## Operation
- A beat is accepted when `s_valid && s_ready`.
- `s_ready` = (state==WAIT_SOF || state==WRITE). It is decoded from the state register only and never depends on `s_valid`.
- **IDLE**
  - `start` goes to WAIT_SOF.
  - `clear` goes to CLEAR. If `clear` and `start` occur in the same cycle, `clear` wins.
- **WAIT_SOF**
  - Accepted beats with `s_sof=0` are discarded, with no write and no error.
  - An accepted beat with `s_sof=1` writes address 0, sets x=1, y=0 and goes to WRITE.
- **WRITE**
  - Each accepted beat writes at the current (x,y).
  - x wraps from H_RES-1 to 0 and increments y.
  - The address is kept as an incrementing counter. No multiplier is used.
  - An accepted beat with `s_sof=1` restarts the frame: it writes address 0, counters become (1,0), and `frame_err` pulses.
  - Accepting beat H_RES*V_RES-1 goes to IDLE, with `done` on the final write.
- **CLEAR** (macro only)
  - `s_ready`=0.
  - Writes `clear_color` to addresses 0..H_RES*V_RES-1, one per cycle, then returns to IDLE with `done`.
  - `clear_color` is sampled when `clear` is accepted.
- `start` and `clear` are ignored while `busy`.
- Counter widths: x is clog2(H_RES) bits, y is clog2(V_RES) bits, and the internal address counter is clog2(H_RES*V_RES) bits. Only the last address, 76799, is compared. There is never an out-of-range write.

## Timing
- Reset values: state=IDLE, `s_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `frame_err`=0, counters=0.
- Latency: a beat accepted in cycle N produces `wr_en`/`wr_addr`/`wr_data` in cycle N+1. All three are registered.
- `start` in cycle N: `s_ready`=1 and `busy`=1 from N+1.
- Full frame: the final beat is accepted in cycle N.
  - Cycle N+1: final write, `done`=1, `busy`=0, `s_ready`=0.
  - A new `start` is accepted from N+1.
- Clear: `clear` in cycle N gives the first write (addr 0) at N+1 and the last write (addr 76799) plus `done` at N+76800.
- `frame_err` is registered and aligned with the write to address 0 that it accompanies.
- Stream stalls (`s_valid` low) hold all counters. `wr_en` is low in stall cycles.
- Reset mid-frame or mid-clear: the next cycle is IDLE with all outputs at reset values. There is no partial-write completion.

## Configuration
- `FB_PAGE_WRITER_CLEAR_EN` defined:
  - `clear` and `clear_color` ports exist.
  - The CLEAR state and its fill logic are built.
- `FB_PAGE_WRITER_CLEAR_EN` undefined:
  - The ports are absent and the CLEAR state is not encoded.
  - `start` is the only exit from IDLE. All other behaviour is identical.

## Structure
- Shared package `fb_pkg`:
  - `FB_H_RES`=320, `FB_V_RES`=240, `FB_PIX_W`=12, `FB_ADDR_W`=19, `FB_PIXELS`=76800.
  - `fb_wr_state_t` enum: IDLE, WAIT_SOF, WRITE, CLEAR.
- One natural sub-module, `fb_raster_counter`:
  - x/y/linear-address counter with `clr` and `inc` inputs and a `last` output.
  - Shared by WRITE and CLEAR.

## Test plan
- Full frame: `start`, then 76800 beats with `s_sof` on the first beat and `s_data`=address[11:0] → writes to 0..76799 with matching data, a single `done` on the write to 76799, and `frame_err` never asserted.
- Pre-SOF junk: `start`, 5 beats with `s_sof`=0, then a frame → no writes for the junk beats and the first write at addr 0.
- Mid-frame SOF: `s_sof` on beat 1000 → `frame_err` pulses with a write to addr 0, and the frame then completes after 76800 further beats.
- Random `s_valid` gaps (≈30% idle) → no write in idle cycles, addresses stay contiguous, and no data is lost.
- Clear with macro: `clear_color`=12'hF00 → 76800 consecutive writes of F00, `done` at cycle N+76800, and `start` in the same cycle as `clear` is ignored.
- `sys_rst` at beat 40000 → outputs reach reset values next cycle, then `start` plus a full frame completes normally.
